// File: rtl/fixed_div.sv
`default_nettype none
// ============================================================================
// Module   : fixed_div
// Purpose  : Sequential signed Q(WIDTH-FRAC).FRAC divider. Restoring radix-2,
//            one quotient bit per cycle, truncation toward zero, saturating.
// Revision : 1.0 - initial release
// ============================================================================
module fixed_div #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             valid_in,
    output logic [WIDTH-1:0] result,
    output logic             valid_out,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int ITER  = WIDTH + FRAC;
    localparam int CNT_W = $clog2(ITER);

    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(ITER - 1);
    localparam logic [ITER-1:0]  c_POS_MAX  = {{(ITER-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [ITER-1:0]  c_NEG_MAX  = {{(ITER-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_SAT_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_SAT_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIV    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_sign;
    logic             r_dz;
    logic [WIDTH-1:0] r_bmag;
    logic [ITER-1:0]  r_num;
    logic [WIDTH:0]   r_rem;
    logic [ITER-1:0]  r_quo;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_valid_out;
    logic             r_busy;
    logic             r_div_by_zero;

    logic [WIDTH-1:0] w_amag;
    logic [WIDTH-1:0] w_bmag;
    logic [WIDTH+1:0] w_rem_shift;
    logic             w_ge;
    logic [WIDTH:0]   w_rem_sub;
    logic [WIDTH-1:0] w_quo_neg;
    logic [WIDTH-1:0] w_final;

    // Magnitude of the most negative value is 2^(WIDTH-1), which still fits
    // as an unsigned WIDTH-bit number.
    assign w_amag = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign w_bmag = b[WIDTH-1] ? (~b + 1'b1) : b;

    // The shifted remainder is kept one bit wider than the stored remainder
    // so the compare never loses the carried-out bit.
    assign w_rem_shift = {r_rem, r_num[ITER-1]};
    assign w_ge        = (w_rem_shift >= {2'b00, r_bmag});
    assign w_rem_sub   = w_rem_shift[WIDTH:0] - {1'b0, r_bmag};

    assign w_quo_neg = ~r_quo[WIDTH-1:0] + 1'b1;

    always_comb begin
        w_final = r_quo[WIDTH-1:0];
        if (r_sign) begin
            w_final = (r_quo > c_NEG_MAX) ? c_SAT_NEG : w_quo_neg;
        end else if (r_quo > c_POS_MAX) begin
            w_final = c_SAT_POS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_result      <= '0;
            r_valid_out   <= 1'b0;
            r_busy        <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_in) begin
                        r_sign  <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_bmag  <= w_bmag;
                        r_num   <= {w_amag, {FRAC{1'b0}}};
                        r_dz    <= (b == '0);
                        r_rem   <= '0;
                        r_quo   <= '0;
                        r_cnt   <= c_CNT_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_num <= {r_num[ITER-2:0], 1'b0};
                    r_quo <= {r_quo[ITER-2:0], w_ge};
                    r_rem <= w_ge ? w_rem_sub : w_rem_shift[WIDTH:0];
                    if (r_cnt == '0) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FINISH: begin
                    r_result      <= w_final;
                    r_div_by_zero <= r_dz;
                    r_valid_out   <= 1'b1;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign result      = r_result;
    assign valid_out   = r_valid_out;
    assign busy        = r_busy;
    assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_fixed_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_fixed_div
// Purpose  : Directed-vector bench for fixed_div (Q4.28 sequential divider).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fixed_div;

    localparam int c_LAT = 61;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        valid_in;
    logic [31:0] result;
    logic        valid_out;
    logic        busy;
    logic        div_by_zero;

    int checks;
    int failures;

    fixed_div #(.WIDTH(32), .FRAC(28)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .valid_in   (valid_in),
        .result     (result),
        .valid_out  (valid_out),
        .busy       (busy),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dz;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present operands before the next rising edge (the accept edge) and
    // return 1 time unit after it.
    task automatic start_op(input logic [31:0] va, input logic [31:0] vb);
        a = va;
        b = vb;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    // Wait for valid_out after an accepted operation, then check latency,
    // busy, result and div_by_zero. Returns 1 time unit after the done edge.
    task automatic wait_done(input string name, input logic [31:0] exp_res, input logic exp_dz);
        int n;
        n = 0;
        check({name, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
        while (!valid_out && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_latency"}, n, c_LAT);
        if (valid_out) begin
            check({name, "_result"}, result, exp_res);
            check({name, "_dz"}, {31'd0, div_by_zero}, {31'd0, exp_dz});
            check({name, "_busy_done"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        int vo_count;
        int vo_edge;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        a        = '0;
        b        = '0;
        valid_in = 1'b0;

        vecs[0]  = '{32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 1'b0};
        vecs[1]  = '{32'h4000_0000, 32'h2000_0000, 32'h2000_0000, 1'b0};
        vecs[2]  = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[3]  = '{32'hF000_0000, 32'h0800_0000, 32'hE000_0000, 1'b0};
        vecs[4]  = '{32'hE800_0000, 32'hE800_0000, 32'h1000_0000, 1'b0};
        vecs[5]  = '{32'h1000_0000, 32'h3000_0000, 32'h0555_5555, 1'b0};
        vecs[6]  = '{32'hF000_0000, 32'h3000_0000, 32'hFAAA_AAAB, 1'b0};
        vecs[7]  = '{32'h4000_0000, 32'h0400_0000, 32'h7FFF_FFFF, 1'b0};
        vecs[8]  = '{32'h8000_0000, 32'h1000_0000, 32'h8000_0000, 1'b0};
        vecs[9]  = '{32'h8000_0000, 32'hF000_0000, 32'h7FFF_FFFF, 1'b0};
        vecs[10] = '{32'h1000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1};
        vecs[11] = '{32'hF000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1};
        vecs[12] = '{32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1};
        vecs[13] = '{32'h2000_0000, 32'h1000_0000, 32'h2000_0000, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_result", result, 32'd0);
        check("reset_valid_out", {31'd0, valid_out}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_dz", {31'd0, div_by_zero}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), vecs[i].res, vecs[i].dz);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_pulse_width", i), {31'd0, valid_out}, 32'd0);
        end

        // valid_in pulses at E10 and E30 must be dropped
        start_op(32'h4000_0000, 32'h2000_0000);
        vo_count = 0;
        vo_edge  = 0;
        for (int k = 1; k <= 140; k++) begin
            if (k == 10 || k == 30) begin
                a = 32'h1000_0000;
                b = 32'h3000_0000;
                valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            @(posedge clk);
            #1;
            if (valid_out) begin
                vo_count++;
                if (vo_edge == 0) vo_edge = k;
                if (vo_count == 1) check("ignore_result", result, 32'h2000_0000);
            end
        end
        valid_in = 1'b0;
        check("ignore_vo_count", vo_count, 1);
        check("ignore_vo_edge", vo_edge, c_LAT);

        // Back-to-back: new request in the valid_out cycle is accepted
        start_op(32'h1000_0000, 32'h1000_0000);
        wait_done("b2b_first", 32'h1000_0000, 1'b0);
        start_op(32'hF000_0000, 32'h0800_0000);
        check("b2b_no_double_pulse", {31'd0, valid_out}, 32'd0);
        wait_done("b2b_second", 32'hE000_0000, 1'b0);

        // Reset at E20 aborts the operation in flight
        @(posedge clk);
        #1;
        start_op(32'h4000_0000, 32'h0400_0000);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid_out", {31'd0, valid_out}, 32'd0);
        check("abort_result", result, 32'd0);
        vo_count = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1;
            if (valid_out) vo_count++;
        end
        check("abort_no_valid_out", vo_count, 0);
        start_op(32'h2000_0000, 32'h1000_0000);
        wait_done("after_abort", 32'h2000_0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
